gb_mem_bus: RTL and testbench

- Sits directly downstream of gb_cpu, on its address/data bus: consumes addr_o/data_o/drive_data_bus and returns read data to data_i.
- Decodes CPU accesses into internal HRAM, the IE register, the OAM port and the external memory bus.
- Contains the OAM DMA engine (FF46), which takes over the external bus and copies 160 bytes into OAM.

---
 rtl/gb_mem_pkg.sv | 28 ++
 rtl/gb_mem_bus_if.sv | 36 +++
 rtl/gb_oam_dma.sv | 71 +++++++
 rtl/gb_mem_bus.sv | 101 ++++++++++
 tb/tb_gb_mem_bus.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_mem_pkg.sv
// Shared constants and types for the Game Boy memory bus: address map,
// OAM DMA length and the DMA state encoding.
package gb_mem_pkg;

   localparam logic [15:0] HRAM_BASE     = 16'hFF80;
   localparam logic [15:0] HRAM_LAST     = 16'hFFFE;
   localparam logic [15:0] IE_ADDR       = 16'hFFFF;
   localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
   localparam logic [15:0] OAM_BASE      = 16'hFE00;
   localparam logic [15:0] OAM_LAST      = 16'hFE9F;
   localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
   localparam logic [15:0] UNUSABLE_LAST = 16'hFEFF;

   localparam int HRAM_SIZE = 127;
   localparam int DMA_LEN   = 160;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_START,
      DMA_XFER
   } dma_state_t;

   // Sources at E0xx and above alias down onto work RAM (echo region).
   function automatic logic [7:0] dma_src_map(input logic [7:0] src);
      return (src >= 8'hE0) ? (src - 8'h20) : src;
   endfunction

endpackage

// File: rtl/gb_mem_bus_if.sv
// Bundle of the CPU-side, external-bus and OAM-port signals around gb_mem_bus,
// plus the DMA state as a debug view.
interface gb_mem_bus_if;
   import gb_mem_pkg::*;

   // There is no valid/ready here: every strobe (cpu_wr_i, ext_wr_o, oam_wr_o)
   // is a single-cycle write qualified by the next posedge, and all read data
   // is combinational from the address presented in the same cycle.
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_data_i;
   logic        cpu_wr_i;
   logic [7:0]  cpu_data_o;
   logic [15:0] ext_addr_o;
   logic [7:0]  ext_data_o;
   logic        ext_wr_o;
   logic [7:0]  ext_data_i;
   logic [7:0]  oam_addr_o;
   logic [7:0]  oam_data_o;
   logic        oam_wr_o;
   logic [7:0]  oam_data_i;
   logic        dma_active_o;
   dma_state_t  dma_state_o;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_wr_i, ext_data_i, oam_data_i,
      output cpu_data_o, ext_addr_o, ext_data_o, ext_wr_o,
      output oam_addr_o, oam_data_o, oam_wr_o, dma_active_o, dma_state_o
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_wr_i, ext_data_i, oam_data_i,
      input  cpu_data_o, ext_addr_o, ext_data_o, ext_wr_o,
      input  oam_addr_o, oam_data_o, oam_wr_o, dma_active_o, dma_state_o
   );

endinterface

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: one START cycle, then DMA_LEN XFER cycles copying
// {src, idx} from the external bus into OAM[idx]. A new start restarts it.
module gb_oam_dma
   import gb_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [7:0]  src_i,
   input  logic [7:0]  ext_data_i,
   output logic        active_o,
   output logic [7:0]  src_o,
   output logic [15:0] ext_addr_o,
   output logic [7:0]  oam_addr_o,
   output logic [7:0]  oam_data_o,
   output logic        oam_wr_o,
   output dma_state_t  state_o
);

   dma_state_t state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] src_q, src_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src_d   = src_q;
      if (start_i) begin
         state_d = DMA_START;
         src_d   = src_i;
         idx_d   = 8'd0;
      end else begin
         case (state_q)
            DMA_START: begin
               state_d = DMA_XFER;
               idx_d   = 8'd0;
            end
            DMA_XFER: begin
               if (idx_q == 8'(DMA_LEN - 1)) begin
                  state_d = DMA_IDLE;
                  idx_d   = 8'd0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
            default: state_d = DMA_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DMA_IDLE;
         idx_q   <= 8'd0;
         src_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
      end
   end

   assign active_o   = (state_q != DMA_IDLE);
   assign src_o      = src_q;
   assign ext_addr_o = {dma_src_map(src_q), idx_q};
   assign oam_addr_o = idx_q;
   assign oam_data_o = ext_data_i;
   assign oam_wr_o   = (state_q == DMA_XFER);
   assign state_o    = state_q;

endmodule

// File: rtl/gb_mem_bus.sv
// CPU address decode, HRAM, IE register, read muxing and external/OAM bus
// ownership between the CPU and the OAM DMA engine.
module gb_mem_bus
   import gb_mem_pkg::*;
(
   input logic         clk,
   input logic         reset,
   gb_mem_bus_if.slave bus
);

   logic [15:0] addr;
   logic is_hi, is_hram, is_ie, is_dma_reg, is_oam, is_unusable, is_ext;

   assign addr = bus.cpu_addr_i;

   always_comb begin
      is_hi       = (addr >= HRAM_BASE);
      is_hram     = (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
      is_ie       = (addr == IE_ADDR);
      is_dma_reg  = (addr == DMA_REG_ADDR);
      is_oam      = (addr >= OAM_BASE) && (addr <= OAM_LAST);
      is_unusable = (addr >= UNUSABLE_BASE) && (addr <= UNUSABLE_LAST);
      is_ext      = !(is_hi || is_dma_reg || is_oam || is_unusable);
   end

   logic        dma_active;
   logic [7:0]  dma_src;
   logic [15:0] dma_ext_addr;
   logic [7:0]  dma_oam_addr;
   logic [7:0]  dma_oam_data;
   logic        dma_oam_wr;
   dma_state_t  dma_state;

   // FF46 writes are honoured even mid-DMA: they restart the transfer.
   gb_oam_dma u_dma (
      .clk        (clk),
      .reset      (reset),
      .start_i    (bus.cpu_wr_i && is_dma_reg),
      .src_i      (bus.cpu_data_i),
      .ext_data_i (bus.ext_data_i),
      .active_o   (dma_active),
      .src_o      (dma_src),
      .ext_addr_o (dma_ext_addr),
      .oam_addr_o (dma_oam_addr),
      .oam_data_o (dma_oam_data),
      .oam_wr_o   (dma_oam_wr),
      .state_o    (dma_state)
   );

   logic [7:0] hram_q [HRAM_SIZE];
   logic [6:0] hram_idx;
   logic [7:0] ie_q, ie_d;

   assign hram_idx = addr[6:0];

   always_comb begin
      ie_d = ie_q;
      if (bus.cpu_wr_i && is_ie) ie_d = bus.cpu_data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ie_q <= 8'h00;
      else       ie_q <= ie_d;
   end

   // HRAM keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (bus.cpu_wr_i && is_hram) hram_q[hram_idx] <= bus.cpu_data_i;
   end

   always_comb begin
      bus.cpu_data_o = bus.ext_data_i;
      if (dma_active && !is_hi)  bus.cpu_data_o = 8'hFF;
      else if (is_hram)          bus.cpu_data_o = hram_q[hram_idx];
      else if (is_ie)            bus.cpu_data_o = ie_q;
      else if (is_dma_reg)       bus.cpu_data_o = dma_src;
      else if (is_oam)           bus.cpu_data_o = bus.oam_data_i;
      else if (is_unusable)      bus.cpu_data_o = 8'hFF;
   end

   always_comb begin
      bus.ext_data_o = bus.cpu_data_i;
      if (dma_active) begin
         bus.ext_addr_o = dma_ext_addr;
         bus.ext_wr_o   = 1'b0;
         bus.oam_addr_o = dma_oam_addr;
         bus.oam_data_o = dma_oam_data;
         bus.oam_wr_o   = dma_oam_wr;
      end else begin
         bus.ext_addr_o = addr;
         bus.ext_wr_o   = bus.cpu_wr_i && is_ext;
         bus.oam_addr_o = addr[7:0];
         bus.oam_data_o = bus.cpu_data_i;
         bus.oam_wr_o   = bus.cpu_wr_i && is_oam;
      end
   end

   assign bus.dma_active_o = dma_active;
   assign bus.dma_state_o  = dma_state;

endmodule

// File: tb/tb_gb_mem_bus.sv
// Directed bench for gb_mem_bus with behavioural external memory and OAM.
module tb_gb_mem_bus;
   import gb_mem_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;

   gb_mem_bus_if bus ();

   gb_mem_bus u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] ext_mem [65536];
   logic [7:0] oam_mem [160];
   int total = 0;
   int bad = 0;
   int ext_wr_cnt = 0;
   int active_cnt = 0;

   assign bus.ext_data_i = ext_mem[bus.ext_addr_o];
   assign bus.oam_data_i = (bus.oam_addr_o < 8'd160) ? oam_mem[bus.oam_addr_o] : 8'h00;

   always @(posedge clk) begin
      if (bus.oam_wr_o && bus.oam_addr_o < 8'd160) oam_mem[bus.oam_addr_o] <= bus.oam_data_o;
      if (bus.ext_wr_o) ext_wr_cnt++;
   end

   always @(negedge clk) begin
      if (bus.dma_active_o) active_cnt++;
   end

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.cpu_addr_i = a;
      bus.cpu_wr_i   = 1'b0;
      #1 d = bus.cpu_data_o;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                            output logic ew, output logic [15:0] ea,
                            output logic [7:0] ed, output logic ow);
      @(negedge clk);
      bus.cpu_addr_i = a;
      bus.cpu_data_i = d;
      bus.cpu_wr_i   = 1'b1;
      #1;
      ew = bus.ext_wr_o;
      ea = bus.ext_addr_o;
      ed = bus.ext_data_o;
      ow = bus.oam_wr_o;
      @(posedge clk);
      #1 bus.cpu_wr_i = 1'b0;
   endtask

   task automatic wait_dma_idle(input int budget, output bit done);
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!bus.dma_active_o) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      #1;
      total++; if (bus.dma_active_o !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", bus.dma_active_o); end
      total++; if (bus.oam_wr_o !== 1'b0) begin bad++; $display("FAIL reset_oam_wr got=%b exp=0", bus.oam_wr_o); end
      total++; if (bus.ext_wr_o !== 1'b0) begin bad++; $display("FAIL reset_ext_wr got=%b exp=0", bus.ext_wr_o); end
      total++; if (bus.dma_state_o !== DMA_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dma_state_o, DMA_IDLE); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cpu_read(16'hFFFF, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_ie got=%h exp=00", d); end
      cpu_read(16'hFF46, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_dma_src got=%h exp=00", d); end
   endtask

   task automatic test_hram_ie();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int e0;
      e0 = ext_wr_cnt;
      cpu_write(16'hFF80, 8'hA5, ew, ea, ed, ow);
      cpu_write(16'hFFFE, 8'h3C, ew, ea, ed, ow);
      cpu_write(16'hFFFF, 8'h1F, ew, ea, ed, ow);
      cpu_read(16'hFF80, d);
      total++; if (d !== 8'hA5) begin bad++; $display("FAIL hram_ff80 got=%h exp=a5", d); end
      cpu_read(16'hFFFE, d);
      total++; if (d !== 8'h3C) begin bad++; $display("FAIL hram_fffe got=%h exp=3c", d); end
      cpu_read(16'hFFFF, d);
      total++; if (d !== 8'h1F) begin bad++; $display("FAIL ie_read got=%h exp=1f", d); end
      total++; if (ext_wr_cnt != e0) begin bad++; $display("FAIL hram_no_ext_wr got=%0d exp=%0d", ext_wr_cnt, e0); end
   endtask

   task automatic test_pass_through();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int e0;
      ext_mem[16'hC000] = 8'h42;
      cpu_read(16'hC000, d);
      total++; if (d !== 8'h42) begin bad++; $display("FAIL pt_read got=%h exp=42", d); end
      e0 = ext_wr_cnt;
      cpu_write(16'hC001, 8'h99, ew, ea, ed, ow);
      total++; if (ew !== 1'b1) begin bad++; $display("FAIL pt_ext_wr got=%b exp=1", ew); end
      total++; if (ea !== 16'hC001) begin bad++; $display("FAIL pt_ext_addr got=%h exp=c001", ea); end
      total++; if (ed !== 8'h99) begin bad++; $display("FAIL pt_ext_data got=%h exp=99", ed); end
      total++; if (ow !== 1'b0) begin bad++; $display("FAIL pt_oam_wr got=%b exp=0", ow); end
      total++; if (ext_wr_cnt - e0 != 1) begin bad++; $display("FAIL pt_wr_cycles got=%0d exp=1", ext_wr_cnt - e0); end
   endtask

   task automatic test_full_dma();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int a0, errs;
      bit done;
      for (int i = 0; i < 160; i++) ext_mem[16'hC100 + i] = 8'(i);
      a0 = active_cnt;
      cpu_write(16'hFF46, 8'hC1, ew, ea, ed, ow);
      wait_dma_idle(400, done);
      total++; if (!done) begin bad++; $display("FAIL dma_timeout got=active exp=idle"); end
      total++; if (active_cnt - a0 != 161) begin bad++; $display("FAIL dma_active_cycles got=%0d exp=161", active_cnt - a0); end
      errs = 0;
      for (int i = 0; i < 160; i++) if (oam_mem[i] !== 8'(i)) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL dma_oam_content got=%0d_bad_bytes exp=0", errs); end
      cpu_read(16'hFF46, d);
      total++; if (d !== 8'hC1) begin bad++; $display("FAIL dma_reg_read got=%h exp=c1", d); end
      total++; if (bus.dma_state_o !== DMA_IDLE) begin bad++; $display("FAIL dma_end_state got=%0d exp=%0d", bus.dma_state_o, DMA_IDLE); end
   endtask

   task automatic test_dma_blocking();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int e0;
      bit done;
      cpu_write(16'hFF46, 8'hC1, ew, ea, ed, ow);
      repeat (20) @(negedge clk);
      cpu_read(16'hC000, d);
      total++; if (d !== 8'hFF) begin bad++; $display("FAIL blk_ext_read got=%h exp=ff", d); end
      e0 = ext_wr_cnt;
      cpu_write(16'hC000, 8'h77, ew, ea, ed, ow);
      total++; if (ew !== 1'b0) begin bad++; $display("FAIL blk_ext_wr got=%b exp=0", ew); end
      total++; if (ext_wr_cnt != e0) begin bad++; $display("FAIL blk_ext_wr_cnt got=%0d exp=%0d", ext_wr_cnt, e0); end
      cpu_write(16'hFF90, 8'h5A, ew, ea, ed, ow);
      cpu_read(16'hFF90, d);
      total++; if (d !== 8'h5A) begin bad++; $display("FAIL blk_hram got=%h exp=5a", d); end
      total++; if (bus.dma_active_o !== 1'b1) begin bad++; $display("FAIL blk_still_active got=%b exp=1", bus.dma_active_o); end
      wait_dma_idle(400, done);
      total++; if (!done) begin bad++; $display("FAIL blk_timeout got=active exp=idle"); end
   endtask

   task automatic test_restart();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int a0, errs;
      bit found, done;
      for (int i = 0; i < 160; i++) begin
         ext_mem[16'hC200 + i] = 8'(i) ^ 8'hA5;
         ext_mem[16'hE200 + i] = 8'h3C;
      end
      a0 = active_cnt;
      cpu_write(16'hFF46, 8'hC1, ew, ea, ed, ow);
      found = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.dma_state_o == DMA_XFER && bus.oam_addr_o == 8'd48) begin
            found = 1'b1;
            break;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL rs_reach_idx got=missing exp=idx48"); end
      // Write lands on the edge that would have advanced idx from 49 to 50.
      cpu_write(16'hFF46, 8'hE2, ew, ea, ed, ow);
      total++; if (bus.dma_state_o !== DMA_START) begin bad++; $display("FAIL rs_state got=%0d exp=%0d", bus.dma_state_o, DMA_START); end
      wait_dma_idle(400, done);
      total++; if (!done) begin bad++; $display("FAIL rs_timeout got=active exp=idle"); end
      total++; if (active_cnt - a0 != 212) begin bad++; $display("FAIL rs_active_cycles got=%0d exp=212", active_cnt - a0); end
      errs = 0;
      for (int i = 0; i < 160; i++) if (oam_mem[i] !== (8'(i) ^ 8'hA5)) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL rs_oam_content got=%0d_bad_bytes exp=0", errs); end
      cpu_read(16'hFF46, d);
      total++; if (d !== 8'hE2) begin bad++; $display("FAIL rs_reg_read got=%h exp=e2", d); end
   endtask

   task automatic test_reset_mid_dma();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      bit found;
      cpu_write(16'hFF46, 8'hC1, ew, ea, ed, ow);
      found = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.dma_state_o == DMA_XFER && bus.oam_addr_o == 8'd10) begin
            found = 1'b1;
            break;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL rm_reach_idx got=missing exp=idx10"); end
      total++; if (bus.oam_wr_o !== 1'b1) begin bad++; $display("FAIL rm_pre_oam_wr got=%b exp=1", bus.oam_wr_o); end
      #2 reset = 1'b1;
      #1;
      total++; if (bus.oam_wr_o !== 1'b0) begin bad++; $display("FAIL rm_oam_wr got=%b exp=0", bus.oam_wr_o); end
      total++; if (bus.dma_active_o !== 1'b0) begin bad++; $display("FAIL rm_active got=%b exp=0", bus.dma_active_o); end
      @(negedge clk);
      reset = 1'b0;
      total++; if (oam_mem[5] !== 8'h05) begin bad++; $display("FAIL rm_kept_byte got=%h exp=05", oam_mem[5]); end
      total++; if (oam_mem[20] !== (8'd20 ^ 8'hA5)) begin bad++; $display("FAIL rm_untouched_byte got=%h exp=b1", oam_mem[20]); end
      cpu_read(16'hFFFF, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rm_ie got=%h exp=00", d); end
      cpu_read(16'hFF46, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rm_dma_src got=%h exp=00", d); end
   endtask

   task automatic test_unusable_oam();
      logic ew, ow;
      logic [15:0] ea;
      logic [7:0] ed, d;
      int e0;
      cpu_read(16'hFEA0, d);
      total++; if (d !== 8'hFF) begin bad++; $display("FAIL unu_read got=%h exp=ff", d); end
      e0 = ext_wr_cnt;
      cpu_write(16'hFEA0, 8'h12, ew, ea, ed, ow);
      total++; if (ew !== 1'b0) begin bad++; $display("FAIL unu_ext_wr got=%b exp=0", ew); end
      total++; if (ow !== 1'b0) begin bad++; $display("FAIL unu_oam_wr got=%b exp=0", ow); end
      total++; if (ext_wr_cnt != e0) begin bad++; $display("FAIL unu_ext_wr_cnt got=%0d exp=%0d", ext_wr_cnt, e0); end
      cpu_read(16'hFE05, d);
      total++; if (d !== 8'h05) begin bad++; $display("FAIL oam_read got=%h exp=05", d); end
      cpu_write(16'hFE10, 8'h6B, ew, ea, ed, ow);
      total++; if (ow !== 1'b1) begin bad++; $display("FAIL oam_cpu_wr got=%b exp=1", ow); end
      total++; if (ew !== 1'b0) begin bad++; $display("FAIL oam_cpu_no_ext got=%b exp=0", ew); end
      @(negedge clk);
      total++; if (oam_mem[16] !== 8'h6B) begin bad++; $display("FAIL oam_cpu_data got=%h exp=6b", oam_mem[16]); end
   endtask

   initial begin
      bus.cpu_addr_i = 16'h0000;
      bus.cpu_data_i = 8'h00;
      bus.cpu_wr_i   = 1'b0;
      test_reset();
      test_hram_ie();
      test_pass_through();
      test_full_dma();
      test_dma_blocking();
      test_restart();
      test_reset_mid_dma();
      test_unusable_oam();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
